// File: rtl/cpu_clk_enable_gen_if.sv
// Board-side control and status bundle for the CPU tick generator.
// master: drives button, mode, rate select, burst length and halt; observes tick outputs.
// slave:  the tick generator itself; consumes the controls and drives cpuEn/busy/btnLevel/tickCount.
interface cpu_clk_enable_gen_if #(
   parameter int RSEL_W  = 1,
   parameter int BURST_W = 8,
   parameter int TICK_W  = 16
);
   logic                clkBtn;     // raw step button, active-low, asynchronous
   logic [1:0]          mode;       // 00 step, 01 burst, 10 divided, 11 full speed
   logic [RSEL_W-1:0]   rateSel;    // divider table index
   logic [BURST_W-1:0]  burstLen;   // ticks per burst
   logic                haltReq;    // freezes tick generation
   logic                cpuEn;      // one-cycle CPU clock enable
   logic                busy;       // burst in progress
   logic                btnLevel;   // debounced button level, 1 = released
   logic [TICK_W-1:0]   tickCount;  // wrapping count of cpuEn pulses

   modport master (
      output clkBtn, mode, rateSel, burstLen, haltReq,
      input  cpuEn, busy, btnLevel, tickCount
   );

   modport slave (
      input  clkBtn, mode, rateSel, burstLen, haltReq,
      output cpuEn, busy, btnLevel, tickCount
   );
endinterface

// File: rtl/cpu_clk_enable_gen.sv
// CPU tick generator: single-cycle clock enable in the board clock domain, with
// step / burst / divided / full-speed modes, button sync+debounce, halt and tick counter.
// Ports: clk, rst (sync, active-high), bus (slave modport: clkBtn, mode, rateSel,
// burstLen, haltReq in; cpuEn, busy, btnLevel, tickCount out, all registered).
module cpu_clk_enable_gen #(
   parameter int                         CNT_W      = 24,
   parameter int                         NUM_DIV    = 2,
   parameter logic [NUM_DIV*CNT_W-1:0]   RATE_DIVS  = {24'd1199999, 24'd11999999},
   parameter int                         RSEL_W     = 1,
   parameter int                         DEB_CYCLES = 120000,
   parameter int                         BURST_W    = 8,
   parameter int                         TICK_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   cpu_clk_enable_gen_if.slave     bus
);

   localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

   localparam logic [1:0] MODE_STEP  = 2'b00;
   localparam logic [1:0] MODE_BURST = 2'b01;
   localparam logic [1:0] MODE_DIV   = 2'b10;
   localparam logic [1:0] MODE_FULL  = 2'b11;

   // Button path
   logic               sync1, sync2;
   logic [DEB_W-1:0]   deb_cnt;
   logic               btn_lvl;
   logic               lvl_d;
   logic               press;

   // Tick path
   logic [1:0]         mode_q;
   logic [RSEL_W-1:0]  sel_q;
   logic [CNT_W-1:0]   div_cnt, div_nxt, div_max;
   logic [BURST_W-1:0] burst_cnt, burst_nxt;
   logic               busy_q, busy_nxt;
   logic               en_q, en_nxt;
   logic [TICK_W-1:0]  tick_q;
   logic               cfg_chg;
   logic               tc;

   // Out-of-range selects fall back to the last table entry.
   function automatic logic [CNT_W-1:0] div_of(input logic [RSEL_W-1:0] s);
      int idx;
      idx = (int'(s) >= NUM_DIV) ? NUM_DIV - 1 : int'(s);
      return RATE_DIVS[idx*CNT_W +: CNT_W];
   endfunction

   // Press is seen in the first cycle the debounced level reads low.
   assign press   = lvl_d & ~btn_lvl;
   assign div_max = div_of(sel_q);
   assign tc      = (div_cnt == div_max);
   assign cfg_chg = (bus.mode != mode_q) || (bus.rateSel != sel_q);

   always_comb begin
      en_nxt    = 1'b0;
      div_nxt   = div_cnt;
      burst_nxt = burst_cnt;
      busy_nxt  = busy_q;
      if (cfg_chg) begin
         // Any mode or rate change restarts timing and abandons a burst.
         div_nxt   = '0;
         burst_nxt = '0;
         busy_nxt  = 1'b0;
      end else if (!bus.haltReq) begin
         unique case (mode_q)
            MODE_STEP: begin
               en_nxt = press;
            end
            MODE_BURST: begin
               if (busy_q) begin
                  if (tc) begin
                     en_nxt    = 1'b1;
                     div_nxt   = '0;
                     burst_nxt = burst_cnt - BURST_W'(1);
                     busy_nxt  = (burst_cnt != BURST_W'(1));
                  end else begin
                     div_nxt = div_cnt + CNT_W'(1);
                  end
               end else if (press && (bus.burstLen != '0)) begin
                  burst_nxt = bus.burstLen;
                  busy_nxt  = 1'b1;
                  div_nxt   = '0;
               end
            end
            MODE_DIV: begin
               if (tc) begin
                  en_nxt  = 1'b1;
                  div_nxt = '0;
               end else begin
                  div_nxt = div_cnt + CNT_W'(1);
               end
            end
            MODE_FULL: begin
               en_nxt = 1'b1;
            end
            default: begin
               en_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         deb_cnt   <= '0;
         btn_lvl   <= 1'b1;
         lvl_d     <= 1'b1;
         mode_q    <= bus.mode;
         sel_q     <= bus.rateSel;
         div_cnt   <= '0;
         burst_cnt <= '0;
         busy_q    <= 1'b0;
         en_q      <= 1'b0;
         tick_q    <= '0;
      end else begin
         sync1 <= bus.clkBtn;
         sync2 <= sync1;
         lvl_d <= btn_lvl;
         // Accept a new level only after DEB_CYCLES consecutive disagreeing samples.
         if (sync2 != btn_lvl) begin
            if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
               btn_lvl <= sync2;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + DEB_W'(1);
            end
         end else begin
            deb_cnt <= '0;
         end

         mode_q    <= bus.mode;
         sel_q     <= bus.rateSel;
         div_cnt   <= div_nxt;
         burst_cnt <= burst_nxt;
         busy_q    <= busy_nxt;
         en_q      <= en_nxt;
         tick_q    <= tick_q + TICK_W'(en_nxt);
      end
   end

   assign bus.cpuEn     = en_q;
   assign bus.busy      = busy_q;
   assign bus.btnLevel  = btn_lvl;
   assign bus.tickCount = tick_q;

endmodule
